// File: rtl/eq_node_param.sv
`default_nettype none
// ============================================================================
//  Module      : eq_node_param
//  Description : Parametrised stochastic equality node of degree DEG for the
//                bit-serial decoder fabric. The DEG-1 check-node bits and the
//                channel bit are merged in two stages. The first stage has
//                NSUB subnodes, and each subnode has a small internal memory
//                (IM). The second stage is a single NSUB-input stage with an
//                edge memory (EM). An output flop follows the second stage.
//                The node also provides a clock enable, a registered HOLD
//                flag, and an EM-ready indicator.
//  Ports       : clk       - clock; all state changes on the rising edge
//                rst       - synchronous active-high reset (overrides i_en)
//                i_en      - clock enable; 0 freezes every register
//                i_init    - initialisation; loads the EM with channel bit
//                i_c       - channel stochastic bit
//                i_r       - DEG-1 stochastic bits from parity-check nodes
//                i_sel     - random address bits (EM addr, then IM addrs)
//                o_q       - registered output stochastic bit
//                o_hold    - final stage used the EM bit last update
//                o_em_rdy  - EM fully loaded (>= EM_S INIT cycles since rst)
//  Revision    : 1.0 - initial release
// ============================================================================
module eq_node_param #(
  parameter int DEG    = 6,
  parameter int SUB_D  = 3,
  parameter int IM_S   = 2,
  parameter int EM_S   = 8,
  parameter int LFSR_S = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_init,
  input  logic              i_c,
  input  logic [DEG-2:0]    i_r,
  input  logic [LFSR_S-1:0] i_sel,
  output logic              o_q,
  output logic              o_hold,
  output logic              o_em_rdy
);

  localparam int NSUB  = DEG / SUB_D;
  localparam int EM_AW = $clog2(EM_S);
  localparam int IM_AW = $clog2(IM_S);
  localparam int CW    = EM_AW + 1;
  localparam logic [CW-1:0] C_EM_FULL = CW'(EM_S);

  // Registered state
  logic [NSUB-1:0] r_s;               // subnode outputs
  logic [IM_S-1:0] r_im [NSUB];       // per-subnode IM, bit 0 = newest
  logic [EM_S-1:0] r_em;              // edge memory, bit 0 = newest
  logic            r_f;               // final-stage output
  logic            r_q;
  logic            r_hold;
  logic [CW-1:0]   r_cnt;             // enabled INIT cycles, saturating

  // Combinational helpers
  logic [DEG-1:0]   w_x;
  logic [NSUB-1:0]  w_all1;
  logic [NSUB-1:0]  w_all0;
  logic [NSUB-1:0]  w_im_rd;
  logic [IM_AW-1:0] w_im_addr [NSUB];
  logic [EM_AW-1:0] w_em_addr;
  logic             w_em_rd;
  logic             w_s_unan;
  logic             w_unused_sel;

  assign w_x       = {i_c, i_r};
  assign w_em_addr = i_sel[EM_AW-1:0];
  assign w_em_rd   = r_em[w_em_addr];
  assign w_s_unan  = (&r_s) | (~|r_s);

  // Any SEL bits above the last IM address field are spare LFSR bits.
  assign w_unused_sel = ^i_sel;

  generate
    for (genvar k = 0; k < NSUB; k++) begin : g_sub
      logic [SUB_D-1:0] w_sub_in;
      assign w_sub_in     = w_x[k*SUB_D +: SUB_D];
      assign w_all1[k]    = &w_sub_in;
      assign w_all0[k]    = ~|w_sub_in;
      assign w_im_addr[k] = i_sel[EM_AW + k*IM_AW +: IM_AW];
      // Read the pre-shift contents. The IM is never written on a hold cycle,
      // so a hold reads the same data it would have read without the shift.
      assign w_im_rd[k]   = r_im[k][w_im_addr[k]];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s    <= '0;
      r_em   <= '0;
      r_f    <= 1'b0;
      r_q    <= 1'b0;
      r_hold <= 1'b0;
      r_cnt  <= '0;
      for (int k = 0; k < NSUB; k++) begin
        r_im[k] <= '0;
      end
    end else if (i_en) begin
      // First stage: a unanimous subnode regenerates and records its bit.
      // Otherwise the subnode replays a stored bit from its IM.
      for (int k = 0; k < NSUB; k++) begin
        if (w_all1[k]) begin
          r_s[k]  <= 1'b1;
          r_im[k] <= {r_im[k][IM_S-2:0], 1'b1};
        end else if (w_all0[k]) begin
          r_s[k]  <= 1'b0;
          r_im[k] <= {r_im[k][IM_S-2:0], 1'b0};
        end else begin
          r_s[k]  <= w_im_rd[k];
        end
      end

      // Final stage. INIT wins over a unanimous subnode vector.
      if (i_init) begin
        r_f    <= i_c;
        r_em   <= {r_em[EM_S-2:0], i_c};
        r_hold <= 1'b0;
        if (r_cnt != C_EM_FULL) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else if (w_s_unan) begin
        r_f    <= r_s[0];
        r_em   <= {r_em[EM_S-2:0], r_s[0]};
        r_hold <= 1'b0;
      end else begin
        r_f    <= w_em_rd;
        r_hold <= 1'b1;
      end

      r_q <= r_f;
    end
  end

  assign o_q      = r_q;
  assign o_hold   = r_hold;
  assign o_em_rdy = (r_cnt == C_EM_FULL);

endmodule
`default_nettype wire
